// File: rtl/seg7_readback_decoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_pkg
//  Brief    : Shared 7-segment pattern/code constants and FSM state encodings
//  Revision : 1.0
// ============================================================================
package seg7_pkg;

    // Segment patterns {a,b,c,d,e,f,g}, active low, decimal point excluded
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] CODE_BLANK   = 4'hA;
    localparam logic [3:0] CODE_INVALID = 4'hF;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SETTLE  = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_HOLD    = 2'd3;

endpackage
`default_nettype wire

// File: rtl/seg7_readback_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_readback_decoder_if
//  Brief    : Segment/anode snoop bus plus decoded readback outputs
//  Revision : 1.0
// ============================================================================
interface seg7_readback_decoder_if #(
    parameter int NDIG = 3,
    parameter int IDXW = 2
);
    logic [7:0]        SEG_IN;
    logic [NDIG-1:0]   AN_IN;
    logic [3:0]        D_OUT;
    logic              DP_OUT;
    logic [IDXW-1:0]   IDX_OUT;
    logic              VALID;
    logic              ERR;
    logic [4*NDIG-1:0] FRAME;

    modport master (
        output SEG_IN, AN_IN,
        input  D_OUT, DP_OUT, IDX_OUT, VALID, ERR, FRAME
    );

    modport slave (
        input  SEG_IN, AN_IN,
        output D_OUT, DP_OUT, IDX_OUT, VALID, ERR, FRAME
    );
endinterface
`default_nettype wire

// File: rtl/seg7_pattern_lookup.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_pattern_lookup
//  Brief    : Combinational 7-bit segment pattern to 4-bit code converter
//  Revision : 1.0
// ============================================================================
module seg7_pattern_lookup
    import seg7_pkg::*;
(
    input  wire logic [6:0] i_pattern,
    output logic      [3:0] o_code,
    output logic            o_invalid
);

    always_comb begin
        o_invalid = 1'b0;
        case (i_pattern)
            SEG_0:     o_code = 4'd0;
            SEG_1:     o_code = 4'd1;
            SEG_2:     o_code = 4'd2;
            SEG_3:     o_code = 4'd3;
            SEG_4:     o_code = 4'd4;
            SEG_5:     o_code = 4'd5;
            SEG_6:     o_code = 4'd6;
            SEG_7:     o_code = 4'd7;
            SEG_8:     o_code = 4'd8;
            SEG_9:     o_code = 4'd9;
            SEG_BLANK: o_code = CODE_BLANK;
            default: begin
                o_code    = CODE_INVALID;
                o_invalid = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seg7_readback_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_readback_decoder
//  Brief    : Samples a multiplexed 7-seg bus, waits for a stable pattern and
//             decodes it back to a digit code with a per-digit frame store
//  Revision : 1.0
// ============================================================================
module seg7_readback_decoder
    import seg7_pkg::*;
#(
    parameter int NDIG          = 3,
    parameter int STABLE_CYCLES = 16,
    parameter int IDXW          = 2
) (
    input  wire logic               CLK,
    input  wire logic               RST,
    seg7_readback_decoder_if.slave  bus
);

    localparam int              CNTW      = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNTW-1:0] C_CNT_MAX = CNTW'(STABLE_CYCLES);
    localparam logic [CNTW-1:0] C_CNT_ONE = CNTW'(1);

    logic [7:0]        r_seg_s1, r_seg_s2, r_ref_seg;
    logic [NDIG-1:0]   r_an_s1,  r_an_s2,  r_ref_an;
    logic [CNTW-1:0]   r_cnt;
    logic [1:0]        r_state;
    logic [3:0]        r_d;
    logic              r_dp;
    logic [IDXW-1:0]   r_idx;
    logic              r_valid;
    logic              r_err;
    logic [4*NDIG-1:0] r_frame;

    logic [NDIG-1:0]   w_an_low;
    logic              w_one_low;
    logic              w_match;
    logic [CNTW-1:0]   w_cnt_inc;
    logic [IDXW-1:0]   w_ref_idx;
    logic [3:0]        w_code;
    logic              w_invalid;

    // Exactly one active-low anode: more than one is a bus conflict
    assign w_an_low  = ~r_an_s2;
    assign w_one_low = (w_an_low != '0) && ((w_an_low & (w_an_low - NDIG'(1))) == '0);
    assign w_match   = (r_seg_s2 == r_ref_seg) && (r_an_s2 == r_ref_an);
    assign w_cnt_inc = (r_cnt == C_CNT_MAX) ? r_cnt : r_cnt + C_CNT_ONE;

    always_comb begin
        w_ref_idx = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (!r_ref_an[i]) w_ref_idx = IDXW'(i);
        end
    end

    seg7_pattern_lookup u_lookup (
        .i_pattern (r_ref_seg[7:1]),
        .o_code    (w_code),
        .o_invalid (w_invalid)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_seg_s1  <= '1;
            r_seg_s2  <= '1;
            r_an_s1   <= '1;
            r_an_s2   <= '1;
            r_ref_seg <= '1;
            r_ref_an  <= '1;
            r_cnt     <= '0;
            r_state   <= ST_IDLE;
            r_d       <= CODE_BLANK;
            r_dp      <= 1'b0;
            r_idx     <= '0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
            r_frame   <= {NDIG{CODE_BLANK}};
        end else begin
            r_seg_s1 <= bus.SEG_IN;
            r_seg_s2 <= r_seg_s1;
            r_an_s1  <= bus.AN_IN;
            r_an_s2  <= r_an_s1;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_one_low) begin
                        r_ref_seg <= r_seg_s2;
                        r_ref_an  <= r_an_s2;
                        r_cnt     <= C_CNT_ONE;
                        r_state   <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (!w_one_low) begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end else if (!w_match) begin
                        r_ref_seg <= r_seg_s2;
                        r_ref_an  <= r_an_s2;
                        r_cnt     <= C_CNT_ONE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_inc == C_CNT_MAX) r_state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    r_d     <= w_code;
                    r_dp    <= ~r_ref_seg[0];
                    r_idx   <= w_ref_idx;
                    r_valid <= 1'b1;
                    r_err   <= w_invalid;
                    for (int i = 0; i < NDIG; i++) begin
                        if (w_ref_idx == IDXW'(i)) r_frame[4*i +: 4] <= w_code;
                    end
                    r_state <= ST_HOLD;
                end
                ST_HOLD: begin
                    // Stay quiet for the rest of this dwell; re-arm on any change
                    if (!w_match) begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.D_OUT   = r_d;
    assign bus.DP_OUT  = r_dp;
    assign bus.IDX_OUT = r_idx;
    assign bus.VALID   = r_valid;
    assign bus.ERR     = r_err;
    assign bus.FRAME   = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_seg7_readback_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg7_readback_decoder
//  Brief    : Directed self-checking bench for seg7_readback_decoder
//  Revision : 1.0
// ============================================================================
module tb_seg7_readback_decoder;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int tests = 0;
    int fails = 0;

    int valid_cnt = 0;
    int err_cnt   = 0;
    int err_alone = 0;
    int n_idx     = 0;
    logic [1:0] idx_log [0:63];

    int base_v, base_e, base_i;

    seg7_readback_decoder_if #(.NDIG(3), .IDXW(2)) bus ();

    seg7_readback_decoder #(
        .NDIG          (3),
        .STABLE_CYCLES (4),
        .IDXW          (2)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Pulse bookkeeping, sampled on the falling edge
    always @(negedge clk) begin
        if (bus.VALID === 1'b1) begin
            valid_cnt++;
            if (n_idx < 64) idx_log[n_idx] = bus.IDX_OUT;
            n_idx++;
        end
        if (bus.ERR === 1'b1) err_cnt++;
        if (bus.ERR === 1'b1 && bus.VALID !== 1'b1) err_alone++;
    end

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] an, input logic [7:0] seg);
        bus.AN_IN  = an;
        bus.SEG_IN = seg;
    endtask

    initial begin
        drive(3'b111, 8'hFF);
        tick(3);
        check("rst_valid", 16'(bus.VALID), 16'h0);
        check("rst_dout",  16'(bus.D_OUT), 16'hA);
        check("rst_frame", 16'(bus.FRAME), 16'hAAA);
        check("rst_idx",   16'(bus.IDX_OUT), 16'h0);
        rst = 1'b0;

        // 1: idle bus, nothing captured
        tick(10);
        check("idle_valids", 16'(valid_cnt), 16'd0);
        check("idle_dout",   16'(bus.D_OUT), 16'hA);
        check("idle_frame",  16'(bus.FRAME), 16'hAAA);
        check("idle_dp",     16'(bus.DP_OUT), 16'h0);

        // 2: digit 0 shows '2', VALID exactly 7 cycles after the input edge
        base_v = valid_cnt;
        drive(3'b110, 8'b00100101);
        tick(6);
        check("lat_pre", 16'(bus.VALID), 16'h0);
        tick(1);
        check("lat_valid", 16'(bus.VALID), 16'h1);
        check("d2_dout",   16'(bus.D_OUT), 16'h2);
        check("d2_dp",     16'(bus.DP_OUT), 16'h0);
        check("d2_idx",    16'(bus.IDX_OUT), 16'h0);
        check("d2_err",    16'(bus.ERR), 16'h0);
        check("d2_frame",  16'(bus.FRAME), 16'hAA2);
        tick(1);
        check("valid_single", 16'(bus.VALID), 16'h0);
        tick(12);
        check("d2_one_valid", 16'(valid_cnt - base_v), 16'd1);

        // 3: sweep three digits
        base_v = valid_cnt;
        base_i = n_idx;
        drive(3'b110, 8'h9F); tick(10);
        drive(3'b101, 8'h0D); tick(10);
        drive(3'b011, 8'h01); tick(10);
        check("sweep_valids", 16'(valid_cnt - base_v), 16'd3);
        check("sweep_idx0",   16'(idx_log[base_i]),     16'd0);
        check("sweep_idx1",   16'(idx_log[base_i + 1]), 16'd1);
        check("sweep_idx2",   16'(idx_log[base_i + 2]), 16'd2);
        check("sweep_frame",  16'(bus.FRAME), 16'h831);
        check("sweep_dout",   16'(bus.D_OUT), 16'h8);

        // 4: blank with dp lit, then an invalid pattern
        base_v = valid_cnt;
        base_e = err_cnt;
        drive(3'b101, 8'b11111110); tick(10);
        check("blank_dout", 16'(bus.D_OUT), 16'hA);
        check("blank_dp",   16'(bus.DP_OUT), 16'h1);
        check("blank_idx",  16'(bus.IDX_OUT), 16'h1);
        check("blank_err",  16'(err_cnt - base_e), 16'd0);
        drive(3'b101, 8'b01010101); tick(10);
        check("inv_dout",    16'(bus.D_OUT), 16'hF);
        check("inv_dp",      16'(bus.DP_OUT), 16'h0);
        check("inv_err",     16'(err_cnt - base_e), 16'd1);
        check("inv_erralone",16'(err_alone), 16'd0);
        check("inv_valids",  16'(valid_cnt - base_v), 16'd2);
        check("inv_frame",   16'(bus.FRAME), 16'h8F1);

        // 5: unstable pattern and anode conflict never capture
        base_v = valid_cnt;
        base_e = err_cnt;
        for (int k = 0; k < 10; k++) begin
            drive(3'b110, (k % 2 == 0) ? 8'h9F : 8'h0D);
            tick(3);
        end
        drive(3'b100, 8'b00100101); tick(20);
        check("noise_valids", 16'(valid_cnt - base_v), 16'd0);
        check("noise_err",    16'(err_cnt - base_e), 16'd0);
        check("noise_dout",   16'(bus.D_OUT), 16'hF);
        check("noise_frame",  16'(bus.FRAME), 16'h8F1);

        // 6: reset during SETTLE, then a full fresh dwell is required
        base_v = valid_cnt;
        drive(3'b110, 8'b00100101);
        tick(5);
        rst = 1'b1;
        tick(1);
        check("mrst_valid", 16'(bus.VALID), 16'h0);
        check("mrst_dout",  16'(bus.D_OUT), 16'hA);
        check("mrst_frame", 16'(bus.FRAME), 16'hAAA);
        rst = 1'b0;
        tick(6);
        check("mrst_pre",    16'(bus.VALID), 16'h0);
        check("mrst_novalid",16'(valid_cnt - base_v), 16'd0);
        tick(1);
        check("mrst_valid2", 16'(bus.VALID), 16'h1);
        check("mrst_dout2",  16'(bus.D_OUT), 16'h2);
        check("mrst_frame2", 16'(bus.FRAME), 16'hAA2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
